// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns the EX/MEM bundle into data-bus load/store requests,
// extracts/extends load data and registers the retiring result toward WB.
// An access in flight is never abandoned; a flush while waiting switches to a
// drain state that swallows the eventual response.
module mem_access_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  input  logic            flush,
  output logic            stall,
  output logic            dbus_valid,
  output logic            dbus_write,
  output logic [XLEN-1:0] dbus_addr,
  output logic [1:0]      dbus_size,
  output logic [7:0]      dbus_strobe,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_data_ok,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            out_misalign
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e state_q, state_d;

  // Latched request fields, stable for the whole bus transaction
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic [7:0]      strobe_q, strobe_d;
  logic            uns_q, uns_d;
  logic            write_q, write_d;
  logic            wen_q, wen_d;
  logic [RD_W-1:0] rd_q, rd_d;

  // MEM/WB bundle registers
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [RD_W-1:0] out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic            out_misalign_q, out_misalign_d;

  logic            mem_op;
  logic            misalign;
  logic            launch;
  logic            retire_alu;
  logic [7:0]      strobe_base;
  logic [7:0]      launch_strobe;
  logic [XLEN-1:0] launch_wdata;
  logic [XLEN-1:0] ld_shifted;
  logic [XLEN-1:0] ld_value;

  assign mem_op     = in_valid & (in_is_load | in_is_store);
  assign launch     = (state_q == StIdle) & mem_op & ~misalign & ~flush;
  // A non-memory instruction sitting in EX/MEM that may leave this cycle
  assign retire_alu = in_valid & ~mem_op & ~flush;

  // Natural-alignment check: address must be a multiple of the access size
  always_comb begin
    misalign = 1'b0;
    unique case (in_size)
      2'd0: misalign = 1'b0;
      2'd1: misalign = in_alu[0];
      2'd2: misalign = |in_alu[1:0];
      2'd3: misalign = |in_alu[2:0];
    endcase
  end

  // Byte-enable mask of the access size before lane alignment
  always_comb begin
    strobe_base = 8'h00;
    unique case (in_size)
      2'd0: strobe_base = 8'h01;
      2'd1: strobe_base = 8'h03;
      2'd2: strobe_base = 8'h0F;
      2'd3: strobe_base = 8'hFF;
    endcase
  end

  assign launch_strobe = strobe_base << in_alu[2:0];
  assign launch_wdata  = in_wdata << {in_alu[2:0], 3'b000};

  // Load data: move the addressed bytes down to lane 0, then extend
  assign ld_shifted = dbus_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_value = ld_shifted;
    unique case (size_q)
      2'd0: ld_value = {{(XLEN-8){~uns_q & ld_shifted[7]}}, ld_shifted[7:0]};
      2'd1: ld_value = {{(XLEN-16){~uns_q & ld_shifted[15]}}, ld_shifted[15:0]};
      2'd2: ld_value = {{(XLEN-32){~uns_q & ld_shifted[31]}}, ld_shifted[31:0]};
      2'd3: ld_value = ld_shifted;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a launched access waits for data_ok; flush diverts to drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (launch) state_d = StWait;
      end
      StWait: begin
        if (dbus_data_ok) begin
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (dbus_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: bus request valid and the EX/MEM hold
  always_comb begin
    dbus_valid = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = launch;
      end
      StWait: begin
        dbus_valid = 1'b1;
        // A flushed instruction need not be held; EX/MEM moves on
        stall      = ~dbus_data_ok & ~flush;
      end
      StDrain: begin
        dbus_valid = 1'b1;
        // New memory op waits one more cycle so it can launch from idle
        stall      = ~flush & (~dbus_data_ok | mem_op);
      end
      default: begin
        dbus_valid = 1'b0;
        stall      = 1'b0;
      end
    endcase
    stall = stall & reset;
  end

  // Request field capture at launch
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    uns_d    = uns_q;
    write_d  = write_q;
    wen_d    = wen_q;
    rd_d     = rd_q;
    if (launch) begin
      addr_d   = in_alu;
      wdata_d  = launch_wdata;
      size_d   = in_size;
      strobe_d = in_is_store ? launch_strobe : 8'h00;
      uns_d    = in_unsigned;
      write_d  = in_is_store;
      wen_d    = in_wen;
      rd_d     = in_rd;
    end
  end

  // Request field registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      uns_q    <= 1'b0;
      write_q  <= 1'b0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      uns_q    <= uns_d;
      write_q  <= write_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
    end
  end

  // Retirement: out_valid pulses for one cycle, other fields hold otherwise
  always_comb begin
    out_valid_d    = 1'b0;
    out_result_d   = out_result_q;
    out_rd_d       = out_rd_q;
    out_wen_d      = out_wen_q;
    out_misalign_d = out_misalign_q;
    unique case (state_q)
      StIdle: begin
        if (retire_alu) begin
          out_valid_d    = 1'b1;
          out_result_d   = in_alu;
          out_rd_d       = in_rd;
          out_wen_d      = in_wen;
          out_misalign_d = 1'b0;
        end else if (mem_op & misalign & ~flush) begin
          out_valid_d    = 1'b1;
          out_result_d   = in_alu;
          out_rd_d       = in_rd;
          out_wen_d      = 1'b0;
          out_misalign_d = 1'b1;
        end
      end
      StWait: begin
        if (dbus_data_ok & ~flush) begin
          out_valid_d    = 1'b1;
          out_rd_d       = rd_q;
          out_misalign_d = 1'b0;
          out_wen_d      = write_q ? 1'b0 : wen_q;
          out_result_d   = write_q ? '0 : ld_value;
        end
      end
      StDrain: begin
        // Response is dropped; a waiting ALU instruction may retire alongside
        if (dbus_data_ok & retire_alu) begin
          out_valid_d    = 1'b1;
          out_result_d   = in_alu;
          out_rd_d       = in_rd;
          out_wen_d      = in_wen;
          out_misalign_d = 1'b0;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // MEM/WB output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_rd_q       <= '0;
      out_wen_q      <= 1'b0;
      out_misalign_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_rd_q       <= out_rd_d;
      out_wen_q      <= out_wen_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign dbus_write   = write_q;
  assign dbus_addr    = addr_q;
  assign dbus_size    = size_q;
  assign dbus_strobe  = strobe_q;
  assign dbus_wdata   = wdata_q;

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_rd       = out_rd_q;
  assign out_wen      = out_wen_q;
  assign out_misalign = out_misalign_q;

endmodule
